uart_wb_fifo_regs: RTL

//   Wishbone register front-end for the UART, with parametrised RX/TX FIFOs, per-source interrupt

---
 rtl/uart_wb_fifo_regs_if.sv | 22 ++
 rtl/uart_wb_fifo_regs.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_fifo_regs_if.sv
// Wishbone slave bus bundle for the UART register front-end.
// Signal names keep the i_/o_ direction as seen from the slave.
// master drives the request; slave returns ack and read data.
interface uart_wb_fifo_regs_if;
  logic        i_wb_valid;
  logic [31:0] i_wb_adr;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport master (
    output i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
    input  o_wb_ack, o_wb_dat
  );

  modport slave (
    input  i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
    output o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/uart_wb_fifo_regs.sv
// Purpose: Wishbone register front-end for the UART with RX/TX FIFOs, IRQ enables, sticky errors.
// Latency: ack and read data one cycle after accept; o_irq lags the register state by one cycle.
// Backpressure: TX drains on valid/ready; full TX drops writes (tx_drop), full RX drops chars (overrun).
// Option: define UART_WB_LOOPBACK_EN to make CTRL[3] an internal TX->RX loopback.
module uart_wb_fifo_regs #(
  parameter int          DATA_W    = 8,
  parameter int          RX_DEPTH  = 4,
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_wb_fifo_regs_if.slave  wb,
  input  logic [DATA_W-1:0]   i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_frame_err,
  output logic [DATA_W-1:0]   o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_irq
);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_PW + 1;
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_PW + 1;

  localparam logic [4:0] OFF_RX    = 5'h00;
  localparam logic [4:0] OFF_TX    = 5'h04;
  localparam logic [4:0] OFF_STAT  = 5'h08;
  localparam logic [4:0] OFF_CTRL  = 5'h0C;
  localparam logic [4:0] OFF_LEVEL = 5'h10;

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] rx_mem_d [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] tx_mem_d [TX_DEPTH];
  logic [RX_PW-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TX_PW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              irq_q, irq_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [2:0]        err_q, err_d;     // {tx_drop, frame_err, overrun}

  logic              addr_hit, accept, rd_acc, wr_acc;
  logic [4:0]        off;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_in_vld, rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
  logic              overrun_ev, frame_ev, drop_ev, lb_on;
  logic [DATA_W-1:0] rx_in_dat, rx_head, tx_head;
  logic [2:0]        w1c;
  logic [6:0]        stat_w;
  logic              unused_wb;

  assign unused_wb = ^{wb.i_wb_dat, wb.i_wb_sel[3:1]};

  // Request decode: one accept per ack, so held valid yields ack every other cycle
  assign addr_hit    = (wb.i_wb_adr[31:5] == BASE_ADDR[31:5]);
  assign off         = wb.i_wb_adr[4:0];
  assign accept      = wb.i_wb_valid && !ack_q;
  assign rd_acc      = accept && !wb.i_wb_we;
  assign wr_acc      = accept && wb.i_wb_we && wb.i_wb_sel[0];

  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign rx_head     = rx_mem_q[rx_rp_q];
  assign tx_head     = tx_mem_q[tx_rp_q];

`ifdef UART_WB_LOOPBACK_EN
  logic lb_move;
  assign lb_on       = ctrl_q[3];
  // In loopback the TX head is moved into RX whenever RX has room; the external RX strobe is ignored
  assign lb_move     = lb_on && !tx_empty && !rx_full;
  assign rx_in_vld   = lb_on ? lb_move : (i_rx_valid && !i_frame_err);
  assign rx_in_dat   = lb_on ? tx_head : i_rx_data;
  assign frame_ev    = !lb_on && i_rx_valid && i_frame_err;
  assign tx_pop      = (o_tx_valid && i_tx_ready) || lb_move;
`else
  assign lb_on       = 1'b0;
  assign rx_in_vld   = i_rx_valid && !i_frame_err;
  assign rx_in_dat   = i_rx_data;
  assign frame_ev    = i_rx_valid && i_frame_err;
  assign tx_pop      = o_tx_valid && i_tx_ready;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign rx_pop      = rd_acc && addr_hit && (off == OFF_RX) && !rx_empty;
  assign rx_push     = rx_in_vld && (!rx_full || rx_pop);
  assign overrun_ev  = rx_in_vld && rx_full && !rx_pop;
  assign tx_push_req = wr_acc && addr_hit && (off == OFF_TX);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign drop_ev     = tx_push_req && tx_full && !tx_pop;

  assign w1c         = (wr_acc && addr_hit && (off == OFF_STAT)) ? wb.i_wb_dat[6:4] : 3'b000;
  assign stat_w      = {err_q, tx_full, tx_empty, rx_full, rx_empty};

  assign o_tx_data   = tx_head;
  assign o_tx_valid  = !tx_empty && !lb_on;
  assign o_irq       = irq_q;
  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_dat = rdat_q;

  // RX FIFO next state: storage, pointers and occupancy
  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wp_q] = rx_in_dat;
      rx_wp_d           = rx_wp_q + RX_PW'(1);
    end
    if (rx_pop) rx_rp_d = rx_rp_q + RX_PW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // TX FIFO next state: storage, pointers and occupancy
  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wp_q] = wb.i_wb_dat[DATA_W-1:0];
      tx_wp_d           = tx_wp_q + TX_PW'(1);
    end
    if (tx_pop) tx_rp_d = tx_rp_q + TX_PW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // Register file next state: ack, read data, CTRL, sticky errors (set beats clear), interrupt
  always_comb begin
    ack_d  = accept;
    rdat_d = rdat_q;
    ctrl_d = ctrl_q;
    err_d  = (err_q & ~w1c) | {drop_ev, frame_ev, overrun_ev};
    irq_d  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | (ctrl_q[2] & (|err_q));
    if (rd_acc) begin
      rdat_d = '0;
      if (addr_hit) begin
        case (off)
          OFF_RX:    rdat_d = rx_empty ? 32'h0 : 32'(rx_head);
          OFF_STAT:  rdat_d = 32'(stat_w);
          OFF_CTRL:  rdat_d = {28'h0, ctrl_q};
          OFF_LEVEL: rdat_d = {16'h0, 8'(tx_cnt_q), 8'(rx_cnt_q)};
          default:   rdat_d = '0;
        endcase
      end
    end
    if (wr_acc && addr_hit && (off == OFF_CTRL)) begin
`ifdef UART_WB_LOOPBACK_EN
      ctrl_d = wb.i_wb_dat[3:0];
`else
      ctrl_d = {1'b0, wb.i_wb_dat[2:0]};
`endif
    end
  end

  // State registers; reset flushes both FIFOs and drops any pending ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      irq_q    <= 1'b0;
      ctrl_q   <= '0;
      err_q    <= '0;
    end else begin
      rx_mem_q <= rx_mem_d;
      tx_mem_q <= tx_mem_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
    end
  end
endmodule
